// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder with start/abort/ack handshake
module serial_add_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         abort,
  input  logic         ack,
  output logic         ready,
  output logic         busy,
  output logic         sbit,
  output logic         valid,
  output logic [N-1:0] q,
  output logic         Cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic          c;
  logic [CW-1:0] cnt;
  logic          s;
  logic          cnext;

  // Full adder on the current LSBs; cnext becomes Cout on the final shift.
  assign s     = ra[0] ^ rb[0] ^ c;
  assign cnext = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign valid = (state == DONE);
  assign sbit  = busy & s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      q     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= A;
            rb    <= B;
            c     <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Abort wins over completion of the final bit.
          if (abort) begin
            state <= IDLE;
            q     <= '0;
            Cout  <= 1'b0;
            c     <= 1'b0;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
          end else begin
            c  <= cnext;
            ra <= ra >> 1;
            rb <= rb >> 1;
            q  <= {s, q[N-1:1]};
            if (cnt == LAST) begin
              cnt   <= '0;
              Cout  <= cnext;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         abort = 1'b0;
  logic         ack = 1'b0;
  logic         ready, busy, sbit, valid, Cout;
  logic [N-1:0] q;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  logic sq[$];

  serial_add_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .abort(abort),
    .ack(ack), .ready(ready), .busy(busy), .sbit(sbit), .valid(valid),
    .q(q), .Cout(Cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted operation owns the sum A+B; sum bit k appears
  // on sbit in the k-th busy cycle, and the full sum shows up after N bits.
  int           m_phase;
  int           m_k;
  logic [N:0]   m_sum;
  logic [N-1:0] m_q;
  logic         m_cout;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_k = 0; m_sum = '0; m_q = '0; m_cout = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_sum = {1'b0, A} + {1'b0, B};
             m_k = 0;
             m_phase = 1;
           end
        1: if (abort) begin
             m_phase = 0; m_q = '0; m_cout = 1'b0;
           end else if (m_k == N - 1) begin
             m_phase = 2; m_q = m_sum[N-1:0]; m_cout = m_sum[N];
           end else begin
             m_k++;
           end
        default: if (ack) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", ready, m_phase == 0);
      chk("busy", busy, m_phase == 1);
      chk("valid", valid, m_phase == 2);
      chk("sbit", sbit, (m_phase == 1) ? m_sum[m_k] : 1'b0);
      if (m_phase != 1) begin
        chk("q", q, m_q);
        chk("Cout", Cout, m_cout);
      end
      if (busy) sq.push_back(sbit);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
    sq.delete();
    A = a; B = b; start = 1'b1;
    step();
    start = 1'b0;
    A = N'($urandom); B = N'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (valid) break;
    end
    if (!valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic do_ack();
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  int cyc;

  initial begin
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_q", q, 0);
    chk("rst_cout", Cout, 0);
    step(); step();
    reset = 1'b1;
    cmp_en = 1'b1;
    step();

    // 3+4: sbits 1,1,1, valid after 4 edges, q=7 Cout=0
    do_start(3'd3, 3'd4);
    wait_valid(cyc);
    chk("lat_3p4", cyc, N + 1);
    chk("sq_3p4", {sq.size() == 3 ? 1'b1 : 1'b0, (sq.size() == 3) ? {sq[2], sq[1], sq[0]} : 3'b000}, 4'b1111);
    chk("q_3p4", q, 7);
    chk("cout_3p4", Cout, 0);
    do_ack();

    // 7+7 with ack held off: result must hold
    do_start(3'd7, 3'd7);
    wait_valid(cyc);
    chk("sq_7p7", {sq.size() == 3 ? 1'b1 : 1'b0, (sq.size() == 3) ? {sq[2], sq[1], sq[0]} : 3'b000}, 4'b1110);
    start = 1'b1;
    A = 3'd1; B = 3'd1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_q", q, 6);
      chk("hold_cout", Cout, 1);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("ack_ready", ready, 1);
    chk("ack_keep_q", q, 6);
    step();

    // start during SHIFT is ignored
    do_start(3'd2, 3'd2);
    start = 1'b1; A = 3'd1; B = 3'd1;
    step();
    start = 1'b0;
    wait_valid(cyc);
    chk("q_ign", q, 4);
    chk("cout_ign", Cout, 0);
    do_ack();

    // abort on 2nd SHIFT edge
    do_start(3'd5, 3'd7);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready, 1);
    chk("abort_q", q, 0);
    chk("abort_cout", Cout, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_novalid", valid, 0);
    end
    step();

    // async reset mid-SHIFT
    do_start(3'd3, 3'd3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_ready", ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_sbit", sbit, 0);
    chk("ar_valid", valid, 0);
    chk("ar_q", q, 0);
    step();
    reset = 1'b1;
    do_start(3'd5, 3'd6);
    wait_valid(cyc);
    chk("q_5p6", q, 3);
    chk("cout_5p6", Cout, 1);
    do_ack();

    // exhaustive back-to-back
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        do_start(N'(a), N'(b));
        wait_valid(cyc);
        chk("exh_sum", {Cout, q}, a + b);
        do_ack();
      end
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      A = N'($urandom);
      B = N'($urandom);
      abort = ($urandom_range(0, 9) == 0);
      ack = ($urandom_range(0, 2) == 0);
      step();
    end
    start = 1'b0; abort = 1'b0; ack = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, meaning operand width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset; reset=0 forces the reset state immediately.
REQ-004 SHALL have port start, input, 1, request to add; accepted only when ready=1.
REQ-005 SHALL have port A, input, N, first operand, sampled on the accepting edge.
REQ-006 SHALL have port B, input, N, second operand, sampled on the accepting edge.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of an operation in progress.
REQ-008 SHALL have port ack, input, 1, result consumed; meaningful only while valid=1.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port busy, output, 1, high only in SHIFT.
REQ-011 SHALL have port sbit, output, 1, sum bit produced in the current SHIFT cycle, LSB first; 0 outside SHIFT.
REQ-012 SHALL have port valid, output, 1, high in DONE; q and Cout are then stable.
REQ-013 SHALL have port q, output, N, registered sum.
REQ-014 SHALL have port Cout, output, 1, registered carry out of the MSB.

Function
REQ-015 SHALL implement the states IDLE, SHIFT and DONE, one-hot or binary, with no other reachable state.
REQ-016 In IDLE, start=1 at an edge SHALL load A and B into internal shift registers, clear the carry flop and bit counter, and enter SHIFT.
REQ-017 In SHIFT, each edge SHALL compute s = a0 ^ b0 ^ c, set c = majority(a0,b0,c), shift both operand registers right by one, shift s into the MSB of the result register, and increment the counter.
REQ-018 sbit SHALL equal the combinational s of the current SHIFT cycle, before the edge that registers it.
REQ-019 After exactly N SHIFT edges (counter reaching N-1 then wrapping) the block SHALL enter DONE; q then holds (A+B) mod 2^N and Cout holds bit N of A+B.
REQ-020 Latency: valid SHALL rise exactly N+1 rising edges after the accepting edge, counting the accepting edge itself.
REQ-021 In DONE, q, Cout and valid SHALL hold until ack=1 at an edge, which SHALL return the block to IDLE with valid=0; q and Cout SHALL retain their values in IDLE.
REQ-022 start while ready=0 SHALL be ignored, with no queuing; A and B changes outside the accepting edge SHALL have no effect.
REQ-023 ack outside DONE SHALL be ignored; start and ack together in DONE SHALL act as ack only, and start is not accepted until the following IDLE cycle.
REQ-024 abort=1 at an edge in SHIFT SHALL return the block to IDLE without asserting valid, clear q, Cout and the carry flop, and take priority over counter completion.
REQ-025 abort=1 in IDLE or DONE SHALL be ignored.
REQ-026 N SHALL size the counter as ceil(log2(N)) bits; no arithmetic overflow beyond Cout SHALL be possible.

Reset
REQ-027 While reset=0, the state SHALL be IDLE; q, Cout, valid, busy, sbit, the carry flop, the counter and the operand registers SHALL be 0, and ready SHALL be 1.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; after release, the first edge with start=1 SHALL begin a fresh operation.

Verification
REQ-029 N=3, A=3, B=4, start pulse -> busy for 3 cycles; sbit sequence 1,1,1; valid after 4 edges; q=7, Cout=0.
REQ-030 N=3, A=7, B=7 -> q=6, Cout=1; sbit sequence 0,1,1; with ack held low 5 cycles, valid, q and Cout stay constant, then ack -> IDLE, ready=1.
REQ-031 start=1 with A=1, B=1 during SHIFT of A=2, B=2 -> ignored; result q=4, Cout=0.
REQ-032 abort=1 on the 2nd SHIFT edge -> ready=1 on the next cycle, valid never asserted, q=0, Cout=0.
REQ-033 reset=0 asynchronously mid-SHIFT (between edges) -> outputs at reset values immediately; after release, A=5, B=6 -> q=3, Cout=1.
REQ-034 Exhaustive N=3: all 64 A/B pairs back-to-back with ack one cycle after valid -> every {Cout,q} equals A+B.
